// File: rtl/write_back_queue_pkg.sv
// Shared widths, queue entry type and context helper for the writeback queue.
// Packet layout per lane: {order, pa_rd, data}.
package write_back_queue_pkg;

  localparam int LEN_PREG_ADDR = 6;
  localparam int LEN_WORD      = 32;
  localparam int LEN_CONTEXT   = 4;
  localparam int LEN_WRITE_D_R = 1 + LEN_PREG_ADDR + LEN_WORD;

  localparam logic [LEN_CONTEXT-1:0] CONTEXT_ZERO = '0;

  typedef struct packed {
    logic                     valid;
    logic [LEN_PREG_ADDR-1:0] pa_rd;
    logic [LEN_WORD-1:0]      data;
    logic [LEN_CONTEXT-1:0]   ctx;
  } wbq_entry_t;

  function automatic logic ctx_hit(
    input logic [LEN_CONTEXT-1:0] a,
    input logic [LEN_CONTEXT-1:0] b
  );
    return (a & b) != CONTEXT_ZERO;
  endfunction

endpackage

// File: rtl/write_back_queue_pack.sv
// Packs one register-write lane: order, pa_rd, data -> write_d_r packet.
// Ports: order/pa_rd/data in, write_d_r out (order is the MSB).
module pack_struct_write_d_r
  import write_back_queue_pkg::*;
(
  input  logic                     order,
  input  logic [LEN_PREG_ADDR-1:0] pa_rd,
  input  logic [LEN_WORD-1:0]      data,
  output logic [LEN_WRITE_D_R-1:0] write_d_r
);

  assign write_d_r = {order, pa_rd, data};

endmodule

// File: rtl/write_back_queue.sv
// Age-ordered writeback queue: collects execute results, squashes by context,
// emits up to WRITE_PARA registered write packets per cycle.
// Ports: clk, rst (async high), src_* in / src_ready out, branch_hazard and
// hazard_context_info in, w_write_d_r packed lanes out, occupancy out.
module write_back_queue
  import write_back_queue_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int WRITE_PARA = 2,
  parameter int DEPTH      = 8
)(
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SRC-1:0]                  src_valid,
  input  logic [LEN_PREG_ADDR*NUM_SRC-1:0]    src_pa_rd,
  input  logic [LEN_WORD*NUM_SRC-1:0]         src_data,
  input  logic [LEN_CONTEXT*NUM_SRC-1:0]      src_context,
  output logic                                src_ready,
  input  logic                                branch_hazard,
  input  logic [LEN_CONTEXT-1:0]              hazard_context_info,
  output logic [LEN_WRITE_D_R*WRITE_PARA-1:0] w_write_d_r,
  output logic [$clog2(DEPTH):0]              occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  wbq_entry_t q_r [DEPTH];
  ptr_t       head_r;
  ptr_t       tail_r;
  cnt_t       count_r;

  // Ready comes from the registered count only, so it never loops
  // back through src_valid.
  assign src_ready = (cnt_t'(DEPTH) - count_r) >= cnt_t'(NUM_SRC);
  assign occupancy = count_r;

  logic [DEPTH-1:0] kill;

  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = branch_hazard &&
                ctx_hit(q_r[i].ctx, hazard_context_info);
    end
  end

  // Enqueue: surviving sources are compacted onto consecutive tail slots.
  logic [NUM_SRC-1:0] src_keep;
  ptr_t               enq_slot [NUM_SRC];
  cnt_t               enq_cnt;

  always_comb begin
    src_keep = '0;
    enq_cnt  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      enq_slot[i] = tail_r + ptr_t'(enq_cnt);
      src_keep[i] = src_ready && src_valid[i] &&
        (src_pa_rd[i*LEN_PREG_ADDR +: LEN_PREG_ADDR] != '0) &&
        !(branch_hazard && ctx_hit(
            src_context[i*LEN_CONTEXT +: LEN_CONTEXT],
            hazard_context_info));
      if (src_keep[i]) enq_cnt = enq_cnt + cnt_t'(1);
    end
  end

  // Head-relative view of the queue for the selection scan.
  logic [DEPTH-1:0]         rot_occ;
  logic [DEPTH-1:0]         rot_live;
  logic [LEN_PREG_ADDR-1:0] rot_pa   [DEPTH];
  logic [LEN_WORD-1:0]      rot_data [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_scan
    ptr_t idx;
    assign idx         = head_r + ptr_t'(k);
    assign rot_occ[k]  = cnt_t'(k) < count_r;
    assign rot_live[k] = q_r[idx].valid && !kill[idx];
    assign rot_pa[k]   = q_r[idx].pa_rd;
    assign rot_data[k] = q_r[idx].data;
  end

  logic [WRITE_PARA-1:0]    lane_on;
  logic [LEN_PREG_ADDR-1:0] lane_pa   [WRITE_PARA];
  logic [LEN_WORD-1:0]      lane_data [WRITE_PARA];
  cnt_t                     ret_cnt;
  int                       nsel;
  logic                     scan_stop;
  logic                     dup;

  // Dead head entries retire for free; a repeated destination ends the
  // scan so each register sees at most one write per cycle, in order.
  always_comb begin
    lane_on   = '0;
    ret_cnt   = '0;
    nsel      = 0;
    scan_stop = 1'b0;
    dup       = 1'b0;
    for (int l = 0; l < WRITE_PARA; l++) begin
      lane_pa[l]   = '0;
      lane_data[l] = '0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (!scan_stop) begin
        if (!rot_occ[k]) begin
          scan_stop = 1'b1;
        end else if (!rot_live[k]) begin
          ret_cnt = ret_cnt + cnt_t'(1);
        end else if (nsel == WRITE_PARA) begin
          scan_stop = 1'b1;
        end else begin
          dup = 1'b0;
          for (int l = 0; l < WRITE_PARA; l++) begin
            if (lane_on[l] && lane_pa[l] == rot_pa[k]) dup = 1'b1;
          end
          if (dup) begin
            scan_stop = 1'b1;
          end else begin
            for (int l = 0; l < WRITE_PARA; l++) begin
              if (l == nsel) begin
                lane_on[l]   = 1'b1;
                lane_pa[l]   = rot_pa[k];
                lane_data[l] = rot_data[k];
              end
            end
            nsel    = nsel + 1;
            ret_cnt = ret_cnt + cnt_t'(1);
          end
        end
      end
    end
  end

  logic [LEN_WRITE_D_R*WRITE_PARA-1:0] lane_pkt;

  for (genvar l = 0; l < WRITE_PARA; l++) begin : g_lane
    pack_struct_write_d_r u_pack (
      .order     (lane_on[l]),
      .pa_rd     (lane_pa[l]),
      .data      (lane_data[l]),
      .write_d_r (lane_pkt[l*LEN_WRITE_D_R +: LEN_WRITE_D_R])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q_r[i] <= '0;
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      w_write_d_r <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i]) q_r[i].valid <= 1'b0;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (cnt_t'(k) < ret_cnt) begin
          q_r[head_r + ptr_t'(k)].valid <= 1'b0;
        end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_keep[i]) begin
          q_r[enq_slot[i]] <= '{
            valid: 1'b1,
            pa_rd: src_pa_rd[i*LEN_PREG_ADDR +: LEN_PREG_ADDR],
            data:  src_data[i*LEN_WORD +: LEN_WORD],
            ctx:   src_context[i*LEN_CONTEXT +: LEN_CONTEXT]
          };
        end
      end
      head_r      <= head_r + ptr_t'(ret_cnt);
      tail_r      <= tail_r + ptr_t'(enq_cnt);
      count_r     <= count_r + enq_cnt - ret_cnt;
      w_write_d_r <= lane_pkt;
    end
  end

endmodule

// File: tb/tb_write_back_queue.sv
// Randomized and directed bench for write_back_queue against a queue-level
// reference model of the writeback ordering rules.
module tb_write_back_queue;
  import write_back_queue_pkg::*;

  localparam int NS = 4;
  localparam int WP = 2;
  localparam int DP = 8;
  localparam int PL = LEN_WRITE_D_R;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NS-1:0]           src_valid = '0;
  logic [LEN_PREG_ADDR*NS-1:0] src_pa_rd = '0;
  logic [LEN_WORD*NS-1:0]  src_data = '0;
  logic [LEN_CONTEXT*NS-1:0] src_context = '0;
  logic                    src_ready;
  logic                    branch_hazard = 1'b0;
  logic [LEN_CONTEXT-1:0]  hazard_context_info = '0;
  logic [PL*WP-1:0]        w_write_d_r;
  logic [$clog2(DP):0]     occupancy;

  write_back_queue #(.NUM_SRC(NS), .WRITE_PARA(WP), .DEPTH(DP)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .src_valid           (src_valid),
    .src_pa_rd           (src_pa_rd),
    .src_data            (src_data),
    .src_context         (src_context),
    .src_ready           (src_ready),
    .branch_hazard       (branch_hazard),
    .hazard_context_info (hazard_context_info),
    .w_write_d_r         (w_write_d_r),
    .occupancy           (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                     v;
    logic [LEN_PREG_ADDR-1:0] pa;
    logic [LEN_WORD-1:0]      d;
    logic [LEN_CONTEXT-1:0]   c;
  } m_ent_t;

  m_ent_t      mq[$];
  logic [PL*WP-1:0] exp_wd = '0;
  int          exp_occ = 0;
  logic        exp_ready = 1'b1;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic idle_inputs();
    src_valid = '0;
    src_pa_rd = '0;
    src_data = '0;
    src_context = '0;
    branch_hazard = 1'b0;
    hazard_context_info = '0;
  endtask

  task automatic set_src(input int i, input int pa,
                         input logic [31:0] d, input int c);
    src_valid[i] = 1'b1;
    src_pa_rd[i*LEN_PREG_ADDR +: LEN_PREG_ADDR] = LEN_PREG_ADDR'(pa);
    src_data[i*LEN_WORD +: LEN_WORD] = d;
    src_context[i*LEN_CONTEXT +: LEN_CONTEXT] = LEN_CONTEXT'(c);
  endtask

  // One clock of the reference: squash, drain from the oldest entry, then
  // accept this cycle's sources; results become visible after the edge.
  task automatic clk_step();
    logic rdy;
    logic [PL*WP-1:0] out;
    logic [LEN_PREG_ADDR-1:0] selpa [WP];
    int n;
    logic dup;
    m_ent_t e;
    rdy = (DP - mq.size()) >= NS;
    if (branch_hazard) begin
      foreach (mq[i]) begin
        if ((mq[i].c & hazard_context_info) != 0) mq[i].v = 1'b0;
      end
    end
    out = '0;
    n = 0;
    while (mq.size() > 0) begin
      if (!mq[0].v) begin
        e = mq.pop_front();
        continue;
      end
      if (n == WP) break;
      dup = 1'b0;
      for (int j = 0; j < n; j++) if (selpa[j] == mq[0].pa) dup = 1'b1;
      if (dup) break;
      out[n*PL +: PL] = {1'b1, mq[0].pa, mq[0].d};
      selpa[n] = mq[0].pa;
      n++;
      e = mq.pop_front();
    end
    if (rdy) begin
      for (int i = 0; i < NS; i++) begin
        e.v  = 1'b1;
        e.pa = src_pa_rd[i*LEN_PREG_ADDR +: LEN_PREG_ADDR];
        e.d  = src_data[i*LEN_WORD +: LEN_WORD];
        e.c  = src_context[i*LEN_CONTEXT +: LEN_CONTEXT];
        if (src_valid[i] && e.pa != 0 &&
            !(branch_hazard && (e.c & hazard_context_info) != 0))
          mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    exp_wd = out;
    exp_occ = mq.size();
    exp_ready = (DP - mq.size()) >= NS;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (w_write_d_r !== '0) begin
      miscompares++;
      $display("FAIL reset_out got %h want 0", w_write_d_r);
    end
    vectors++;
    if (occupancy !== '0) begin
      miscompares++;
      $display("FAIL reset_occ got %0d want 0", occupancy);
    end
    vectors++;
    if (src_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got %b want 1", src_ready);
    end
    rst = 1'b0;
    mq.delete();
    exp_wd = '0;
    exp_occ = 0;
    exp_ready = 1'b1;
  endtask

  task automatic test_two_sources();
    logic [PL*WP-1:0] want;
    want = {1'b1, 6'd7, 32'h22, 1'b1, 6'd5, 32'h11};
    idle_inputs();
    set_src(0, 5, 32'h11, 1);
    set_src(2, 7, 32'h22, 1);
    for (int c = 0; c < 3; c++) begin
      clk_step();
      idle_inputs();
      vectors++;
      if (w_write_d_r !== exp_wd) begin
        miscompares++;
        $display("FAIL two_src_out c%0d got %h want %h", c, w_write_d_r, exp_wd);
      end
      vectors++;
      if (occupancy !== 4'(exp_occ)) begin
        miscompares++;
        $display("FAIL two_src_occ c%0d got %0d want %0d", c, occupancy, exp_occ);
      end
      if (c == 1) begin
        vectors++;
        if (w_write_d_r !== want) begin
          miscompares++;
          $display("FAIL two_src_lanes got %h want %h", w_write_d_r, want);
        end
      end
    end
  endtask

  task automatic test_same_reg();
    idle_inputs();
    set_src(0, 9, 32'hA, 1);
    set_src(1, 9, 32'hB, 1);
    for (int c = 0; c < 4; c++) begin
      clk_step();
      idle_inputs();
      vectors++;
      if (w_write_d_r !== exp_wd) begin
        miscompares++;
        $display("FAIL same_reg_out c%0d got %h want %h", c, w_write_d_r, exp_wd);
      end
      vectors++;
      if (occupancy !== 4'(exp_occ)) begin
        miscompares++;
        $display("FAIL same_reg_occ c%0d got %0d want %0d", c, occupancy, exp_occ);
      end
    end
  endtask

  task automatic test_squash();
    idle_inputs();
    set_src(0, 3, 32'h33, 1);
    set_src(1, 4, 32'h44, 2);
    for (int c = 0; c < 4; c++) begin
      clk_step();
      idle_inputs();
      if (c == 0) begin
        branch_hazard = 1'b1;
        hazard_context_info = 4'b0001;
        set_src(2, 0, 32'h55, 2);
        set_src(3, 10, 32'h66, 1);
      end
      vectors++;
      if (w_write_d_r !== exp_wd) begin
        miscompares++;
        $display("FAIL squash_out c%0d got %h want %h", c, w_write_d_r, exp_wd);
      end
      vectors++;
      if (occupancy !== 4'(exp_occ)) begin
        miscompares++;
        $display("FAIL squash_occ c%0d got %0d want %0d", c, occupancy, exp_occ);
      end
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 12; c++) begin
      idle_inputs();
      if (c < 2) begin
        for (int i = 0; i < NS; i++) set_src(i, 6, 32'(c*NS + i + 1), 4);
      end
      clk_step();
      vectors++;
      if (w_write_d_r !== exp_wd) begin
        miscompares++;
        $display("FAIL stall_out c%0d got %h want %h", c, w_write_d_r, exp_wd);
      end
      vectors++;
      if (src_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL stall_ready c%0d got %b want %b", c, src_ready, exp_ready);
      end
      vectors++;
      if (occupancy !== 4'(exp_occ)) begin
        miscompares++;
        $display("FAIL stall_occ c%0d got %0d want %0d", c, occupancy, exp_occ);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      if ($urandom_range(0, 7) != 0) begin
        for (int i = 0; i < NS; i++) begin
          if ($urandom_range(0, 1) == 1)
            set_src(i, $urandom_range(0, 7), $urandom, $urandom_range(1, 15));
        end
      end
      if ($urandom_range(0, 9) == 0) begin
        branch_hazard = 1'b1;
        hazard_context_info = LEN_CONTEXT'($urandom_range(1, 15));
      end
      clk_step();
      vectors++;
      if (w_write_d_r !== exp_wd) begin
        miscompares++;
        $display("FAIL rand_out c%0d got %h want %h", c, w_write_d_r, exp_wd);
      end
      vectors++;
      if (src_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL rand_ready c%0d got %b want %b", c, src_ready, exp_ready);
      end
      vectors++;
      if (occupancy !== 4'(exp_occ)) begin
        miscompares++;
        $display("FAIL rand_occ c%0d got %0d want %0d", c, occupancy, exp_occ);
      end
    end
    idle_inputs();
    repeat (8) clk_step();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    for (int i = 0; i < NS; i++) set_src(i, 6, 32'h100 + 32'(i), 1);
    clk_step();
    idle_inputs();
    set_src(0, 6, 32'h200, 1);
    set_src(1, 6, 32'h201, 1);
    clk_step();
    idle_inputs();
    vectors++;
    if (occupancy !== 4'(exp_occ)) begin
      miscompares++;
      $display("FAIL mid_pre_occ got %0d want %0d", occupancy, exp_occ);
    end
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (w_write_d_r !== '0) begin
      miscompares++;
      $display("FAIL mid_rst_out got %h want 0", w_write_d_r);
    end
    vectors++;
    if (occupancy !== '0) begin
      miscompares++;
      $display("FAIL mid_rst_occ got %0d want 0", occupancy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    mq.delete();
    for (int c = 0; c < 4; c++) begin
      clk_step();
      vectors++;
      if (w_write_d_r !== '0) begin
        miscompares++;
        $display("FAIL mid_after_out c%0d got %h want 0", c, w_write_d_r);
      end
      vectors++;
      if (occupancy !== 4'(exp_occ)) begin
        miscompares++;
        $display("FAIL mid_after_occ c%0d got %0d want %0d", c, occupancy, exp_occ);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_sources();
    test_same_reg();
    test_squash();
    test_stall();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
